// File: rtl/writeback_stage_pkg.sv
// Shared core definitions for the writeback stage.
//   - XLEN: architectural register width.
//   - Load funct3 encodings used by the load aligner.
//   - Writeback FSM state type.
//   - Captured-load context record, filled when a load is accepted.
package writeback_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    WB_IDLE      = 1'b0,
    WB_WAIT_LOAD = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic       rd_write;
    logic [4:0] rd_addr;
    logic [2:0] funct3;
    logic [1:0] addr_low;
  } load_ctx_t;

endpackage

// File: rtl/writeback_stage_load_align.sv
// load_align: selects and extends the loaded byte/half/word.
// Ports:
//   funct3   in  3   load width/sign code
//   addr_low in  2   effective address bits [1:0]
//   raw      in  32  aligned word from data memory
//   ext_data out 32  sign/zero-extended register value
// Halves are selected by addr_low[1] only; misalignment is not trapped here.
// Reserved codes (011/110/111) fall through to a full-word load.
module load_align
  import writeback_stage_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_low,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] ext_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign sel_byte = raw[8*addr_low +: 8];
  assign sel_half = addr_low[1] ? raw[31:16] : raw[15:0];

  // NOTE: the output gets a default before the case so every path assigns it;
  // a missed branch in always_comb would otherwise infer a latch.
  always_comb begin
    ext_data = raw;
    case (funct3)
      F3_LB:   ext_data = {{24{sel_byte[7]}}, sel_byte};
      F3_LH:   ext_data = {{16{sel_half[15]}}, sel_half};
      F3_LBU:  ext_data = {24'b0, sel_byte};
      F3_LHU:  ext_data = {16'b0, sel_half};
      default: ext_data = raw;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage. Retires memory-stage instructions,
// completes the single outstanding load, drives the register-file write
// port and counts retired instructions.
// Ports:
//   clk, rst                   clock, async active-low reset
//   memValid/memIsLoad/...     retiring instruction from the memory stage
//   dmemRspValid, dmemRdata    load response (single-cycle pulse)
//   stall                      combinational hold request to upstream
//   rdWrite, rdAddr, rdData    registered register-file write port
//   instret                    64-bit retired-instruction counter
module writeback_stage
  import writeback_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            memValid,
  input  logic            memIsLoad,
  input  logic            memRdWrite,
  input  logic [4:0]      memRdAddr,
  input  logic [2:0]      memFunct3,
  input  logic [1:0]      memAddrLow,
  input  logic [XLEN-1:0] memAluResult,
  input  logic            dmemRspValid,
  input  logic [XLEN-1:0] dmemRdata,
  output logic            stall,
  output logic            rdWrite,
  output logic [4:0]      rdAddr,
  output logic [XLEN-1:0] rdData,
  output logic [63:0]     instret
);

  wb_state_e       state, state_next;
  load_ctx_t       load_ctx;
  logic            accept;
  logic [XLEN-1:0] load_data;

  load_align u_load_align (
    .funct3   (load_ctx.funct3),
    .addr_low (load_ctx.addr_low),
    .raw      (dmemRdata),
    .ext_data (load_data)
  );

  // Stall is held through the response cycle so the load owns the write
  // port that cycle; the waiting instruction is accepted the cycle after.
  assign stall  = (state == WB_WAIT_LOAD) && memValid;
  assign accept = memValid && !stall;

  always_comb begin
    state_next = state;
    case (state)
      WB_IDLE:      if (accept && memIsLoad) state_next = WB_WAIT_LOAD;
      WB_WAIT_LOAD: if (dmemRspValid)        state_next = WB_IDLE;
      default:      state_next = WB_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= WB_IDLE;
      load_ctx <= '0;
      rdWrite  <= 1'b0;
      rdAddr   <= '0;
      rdData   <= '0;
      instret  <= '0;
    end else begin
      state   <= state_next;
      rdWrite <= 1'b0;
      case (state)
        WB_IDLE: begin
          if (accept) begin
            if (memIsLoad) begin
              load_ctx <= '{rd_write: memRdWrite, rd_addr: memRdAddr,
                            funct3: memFunct3, addr_low: memAddrLow};
            end else begin
              rdWrite <= memRdWrite && (memRdAddr != 5'd0);
              rdAddr  <= memRdAddr;
              rdData  <= memAluResult;
              instret <= instret + 64'd1;
            end
          end
        end
        WB_WAIT_LOAD: begin
          if (dmemRspValid) begin
            rdWrite <= load_ctx.rd_write && (load_ctx.rd_addr != 5'd0);
            rdAddr  <= load_ctx.rd_addr;
            rdData  <= load_data;
            instret <= instret + 64'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: a table of single-instruction
// vectors (ALU ops and loads of every width/offset) plus hand-written
// sequences for stall, x0, reset-during-load and counter wrap.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        memValid, memIsLoad, memRdWrite;
  logic [4:0]  memRdAddr;
  logic [2:0]  memFunct3;
  logic [1:0]  memAddrLow;
  logic [31:0] memAluResult;
  logic        dmemRspValid;
  logic [31:0] dmemRdata;
  logic        stall, rdWrite;
  logic [4:0]  rdAddr;
  logic [31:0] rdData;
  logic [63:0] instret;

  writeback_stage dut (
    .clk          (clk),
    .rst          (rst),
    .memValid     (memValid),
    .memIsLoad    (memIsLoad),
    .memRdWrite   (memRdWrite),
    .memRdAddr    (memRdAddr),
    .memFunct3    (memFunct3),
    .memAddrLow   (memAddrLow),
    .memAluResult (memAluResult),
    .dmemRspValid (dmemRspValid),
    .dmemRdata    (dmemRdata),
    .stall        (stall),
    .rdWrite      (rdWrite),
    .rdAddr       (rdAddr),
    .rdData       (rdData),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  logic [63:0] exp_instret = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    memValid     = 1'b0;
    memIsLoad    = 1'b0;
    memRdWrite   = 1'b0;
    memRdAddr    = '0;
    memFunct3    = '0;
    memAddrLow   = '0;
    memAluResult = '0;
    dmemRspValid = 1'b0;
    dmemRdata    = '0;
  endtask

  task automatic drive_instr(input logic is_load, input logic rd_write, input logic [4:0] rd,
                             input logic [2:0] f3, input logic [1:0] al, input logic [31:0] alu);
    memValid     = 1'b1;
    memIsLoad    = is_load;
    memRdWrite   = rd_write;
    memRdAddr    = rd;
    memFunct3    = f3;
    memAddrLow   = al;
    memAluResult = alu;
  endtask

  typedef struct {
    string       name;
    logic        is_load;
    logic        rd_write;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [1:0]  al;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic        exp_write;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{"alu_rd5",     0, 1, 5'd5,  3'b000, 2'd0, 32'h1234_5678, 32'h0,         1, 32'h1234_5678};
    vecs[1]  = '{"lb_a2",       1, 1, 5'd3,  3'b000, 2'd2, 32'h0,         32'h0080_FF00, 1, 32'hFFFF_FF80};
    vecs[2]  = '{"lbu_a2",      1, 1, 5'd3,  3'b100, 2'd2, 32'h0,         32'h0080_FF00, 1, 32'h0000_0080};
    vecs[3]  = '{"lh_a2",       1, 1, 5'd3,  3'b001, 2'd2, 32'h0,         32'h0080_FF00, 1, 32'h0000_0080};
    vecs[4]  = '{"lhu_a0",      1, 1, 5'd3,  3'b101, 2'd0, 32'h0,         32'h0080_FF00, 1, 32'h0000_FF00};
    vecs[5]  = '{"lh_a0",       1, 1, 5'd4,  3'b001, 2'd0, 32'h0,         32'h0080_FF00, 1, 32'hFFFF_FF00};
    vecs[6]  = '{"lb_a1",       1, 1, 5'd6,  3'b000, 2'd1, 32'h0,         32'h0080_FF00, 1, 32'hFFFF_FFFF};
    vecs[7]  = '{"lb_a3",       1, 1, 5'd7,  3'b000, 2'd3, 32'h0,         32'h0080_FF00, 1, 32'h0000_0000};
    vecs[8]  = '{"lw_a3",       1, 1, 5'd8,  3'b010, 2'd3, 32'h0,         32'h0080_FF00, 1, 32'h0080_FF00};
    vecs[9]  = '{"f3_011",      1, 1, 5'd9,  3'b011, 2'd1, 32'h0,         32'hCAFE_0123, 1, 32'hCAFE_0123};
    vecs[10] = '{"lh_a3",       1, 1, 5'd10, 3'b001, 2'd3, 32'h0,         32'h8001_7FFF, 1, 32'hFFFF_8001};
    vecs[11] = '{"lhu_a1",      1, 1, 5'd11, 3'b101, 2'd1, 32'h0,         32'h8001_8FFF, 1, 32'h0000_8FFF};
    vecs[12] = '{"f3_110",      1, 1, 5'd12, 3'b110, 2'd0, 32'h0,         32'hDEAD_BEEF, 1, 32'hDEAD_BEEF};
    vecs[13] = '{"f3_111",      1, 1, 5'd31, 3'b111, 2'd2, 32'h0,         32'h8765_4321, 1, 32'h8765_4321};
    vecs[14] = '{"alu_nowrite", 0, 0, 5'd7,  3'b000, 2'd0, 32'h5555_AAAA, 32'h0,         0, 32'h0};
    vecs[15] = '{"alu_x0",      0, 1, 5'd0,  3'b000, 2'd0, 32'h0BAD_F00D, 32'h0,         0, 32'h0};
    vecs[16] = '{"lw_x0",       1, 1, 5'd0,  3'b010, 2'd0, 32'h0,         32'h0BAD_0BAD, 0, 32'h0};
  end

  initial begin
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_rdWrite", rdWrite, 0);
    check("reset_rdAddr", rdAddr, 0);
    check("reset_rdData", rdData, 0);
    check("reset_instret", instret, 0);
    check("reset_stall", stall, 0);
    rst = 1'b1;

    // Table-driven single instructions, loads answered three cycles later.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive_instr(vecs[i].is_load, vecs[i].rd_write, vecs[i].rd, vecs[i].f3, vecs[i].al, vecs[i].alu);
      @(negedge clk);
      idle_inputs();
      if (vecs[i].is_load) begin
        check({vecs[i].name, "_early"}, rdWrite, 0);
        repeat (2) @(negedge clk);
        dmemRspValid = 1'b1;
        dmemRdata    = vecs[i].rdata;
        @(negedge clk);
        idle_inputs();
      end
      exp_instret++;
      check({vecs[i].name, "_rdWrite"}, rdWrite, vecs[i].exp_write);
      if (vecs[i].exp_write) begin
        check({vecs[i].name, "_rdAddr"}, rdAddr, vecs[i].rd);
        check({vecs[i].name, "_rdData"}, rdData, vecs[i].exp_data);
      end
      check({vecs[i].name, "_instret"}, instret, exp_instret);
      @(negedge clk);
      check({vecs[i].name, "_pulse"}, rdWrite, 0);
    end

    // Back-to-back ALU ops: one write per cycle.
    drive_instr(0, 1, 5'd1, 3'b000, 2'd0, 32'h0000_0001);
    @(negedge clk);
    check("b2b_first_write", rdWrite, 1);
    check("b2b_first_data", rdData, 32'h0000_0001);
    drive_instr(0, 1, 5'd2, 3'b000, 2'd0, 32'h0000_0002);
    @(negedge clk);
    idle_inputs();
    exp_instret += 2;
    check("b2b_second_write", rdWrite, 1);
    check("b2b_second_addr", rdAddr, 5'd2);
    check("b2b_second_data", rdData, 32'h0000_0002);
    check("b2b_instret", instret, exp_instret);

    // Response while idle is ignored.
    dmemRspValid = 1'b1;
    dmemRdata    = 32'hFFFF_FFFF;
    @(negedge clk);
    idle_inputs();
    check("idle_rsp_write", rdWrite, 0);
    check("idle_rsp_instret", instret, exp_instret);

    // Load followed by a held ALU op: stall through the response cycle.
    drive_instr(1, 1, 5'd9, 3'b010, 2'd0, 32'h0);
    @(negedge clk);
    drive_instr(0, 1, 5'd10, 3'b000, 2'd0, 32'h0000_A5A5);
    check("hold_stall_0", stall, 1);
    @(negedge clk);
    check("hold_stall_1", stall, 1);
    check("hold_no_write", rdWrite, 0);
    dmemRspValid = 1'b1;
    dmemRdata    = 32'h1111_2222;
    check("hold_stall_rsp", stall, 1);
    @(negedge clk);
    dmemRspValid = 1'b0;
    check("hold_load_write", rdWrite, 1);
    check("hold_load_addr", rdAddr, 5'd9);
    check("hold_load_data", rdData, 32'h1111_2222);
    check("hold_stall_released", stall, 0);
    @(negedge clk);
    idle_inputs();
    exp_instret += 2;
    check("hold_alu_write", rdWrite, 1);
    check("hold_alu_addr", rdAddr, 5'd10);
    check("hold_alu_data", rdData, 32'h0000_A5A5);
    check("hold_instret", instret, exp_instret);

    // LW to x0 followed by ALU to x0: waits, no writes, both retire.
    drive_instr(1, 1, 5'd0, 3'b010, 2'd0, 32'h0);
    @(negedge clk);
    drive_instr(0, 1, 5'd0, 3'b000, 2'd0, 32'h7777_7777);
    check("x0_stall", stall, 1);
    @(negedge clk);
    check("x0_stall_wait", stall, 1);
    dmemRspValid = 1'b1;
    dmemRdata    = 32'h3333_3333;
    @(negedge clk);
    dmemRspValid = 1'b0;
    check("x0_load_no_write", rdWrite, 0);
    @(negedge clk);
    idle_inputs();
    exp_instret += 2;
    check("x0_alu_no_write", rdWrite, 0);
    check("x0_instret", instret, exp_instret);

    // Reset asserted while a load is outstanding drops it.
    drive_instr(1, 1, 5'd4, 3'b010, 2'd0, 32'h0);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstwait_rdAddr", rdAddr, 0);
    check("rstwait_rdData", rdData, 0);
    check("rstwait_instret", instret, 0);
    @(negedge clk);
    rst = 1'b1;
    exp_instret = '0;
    memValid = 1'b1;
    #1;
    check("rstwait_stall_idle", stall, 0);
    memValid = 1'b0;
    dmemRspValid = 1'b1;
    dmemRdata    = 32'h4444_4444;
    @(negedge clk);
    idle_inputs();
    check("rstwait_rsp_write", rdWrite, 0);
    check("rstwait_rsp_data", rdData, 0);
    check("rstwait_rsp_instret", instret, exp_instret);

    // Counter wrap from all-ones.
    force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret;
    drive_instr(0, 1, 5'd13, 3'b000, 2'd0, 32'h0000_0013);
    @(negedge clk);
    idle_inputs();
    check("wrap_write", rdWrite, 1);
    check("wrap_instret", instret, 64'd0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
